// File: rtl/tff_ctrl_pkg.sv
// Shared types and helpers for the T flip-flop counter controller.
// Contents:
//   state_t      - controller state (IDLE, RUN)
//   DEF_DIV_MAX  - default divider terminal value (1 Hz step at 50 MHz)
//   DEF_DIV_W    - default divider register width
//   t_vector()   - per-bit toggle vector that moves q to next
package tff_ctrl_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int unsigned DEF_DIV_MAX = 49_999_999;
  localparam int unsigned DEF_DIV_W   = 26;

  // Widest counter the helper supports; callers size-cast in and out.
  localparam int unsigned T_MAX_W = 32;

  // A T flip-flop bank reaches 'next' from 'q' by toggling exactly the
  // bits that differ.
  function automatic logic [T_MAX_W-1:0] t_vector(
    input logic [T_MAX_W-1:0] q,
    input logic [T_MAX_W-1:0] next
  );
    return q ^ next;
  endfunction

endpackage

// File: rtl/t_flipflop.sv
// Single T flip-flop cell with synchronous active-low reset.
// Ports:
//   clock  - clock
//   resetn - synchronous, active-low reset (q -> 0)
//   t      - toggle enable
//   q      - stored bit
module t_flipflop (
  input  logic clock,
  input  logic resetn,
  input  logic t,
  output logic q
);

  always_ff @(posedge clock) begin
    if (!resetn)
      q <= 1'b0;
    else if (t)
      q <= ~q;
  end

endmodule

// File: rtl/tick_divider.sv
// Rate divider producing one tick every DIV_MAX+1 enabled cycles.
// Ports:
//   clock  - clock
//   resetn - synchronous, active-low reset (div -> 0)
//   clear  - synchronous clear of the divider count
//   en     - count enable
//   tick   - combinational, high while enabled and div == DIV_MAX
//   div    - current divider count
module tick_divider
  import tff_ctrl_pkg::*;
#(
  parameter int unsigned DIV_MAX = DEF_DIV_MAX,
  parameter int unsigned DIV_W   = DEF_DIV_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             en,
  output logic             tick,
  output logic [DIV_W-1:0] div
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV_MAX);

  always_ff @(posedge clock) begin
    if (!resetn || clear)
      div <= '0;
    else if (en)
      div <= (div == TERM) ? '0 : div + DIV_W'(1);
  end

  assign tick = en && (div == TERM);

endmodule

// File: rtl/tff_count_controller.sv
// Paced up/down counter built from a bank of T flip-flops.
// Ports:
//   clock  - system clock (CLOCK_50)
//   resetn - synchronous, active-low reset
//   start  - begins a run when idle
//   stop   - aborts a run; beats start and tick
//   dir    - 1 = up, 0 = down; sampled at each tick
//   wrap   - 1 = wrap at terminal, 0 = halt; sampled at each tick
//   limit  - upper bound of the count range [0, limit]
//   q      - counter value
//   tick   - high in the cycle a step is applied
//   busy   - high while running
//   done   - one-cycle pulse after a non-wrapping terminal halt
module tff_count_controller
  import tff_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DIV_MAX = DEF_DIV_MAX,
  parameter int unsigned DIV_W   = DEF_DIV_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             wrap,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [WIDTH-1:0] t, next;
  logic [DIV_W-1:0] div;
  logic             div_en, div_tick, terminal, halt;

  // The divider only runs in RUN without stop, so its tick already
  // carries the "running and not stopping" qualification.
  assign div_en = (state == RUN) && !stop;

  tick_divider #(
    .DIV_MAX (DIV_MAX),
    .DIV_W   (DIV_W)
  ) u_div (
    .clock  (clock),
    .resetn (resetn),
    .clear  (!div_en),
    .en     (div_en),
    .tick   (div_tick),
    .div    (div)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_flipflop u_tff (
      .clock  (clock),
      .resetn (resetn),
      .t      (t[i]),
      .q      (q[i])
    );
  end

  // State register and done pulse.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= halt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !stop) state_next = RUN;
      RUN:     if (stop || halt)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs and step computation. Up-terminal uses >= so a limit lowered
  // below q is treated as reached rather than counting past it.
  always_comb begin
    busy     = (state == RUN);
    tick     = div_tick;
    terminal = dir ? (q >= limit) : (q == '0);
    if (dir)
      next = terminal ? (wrap ? '0 : q) : q + WIDTH'(1);
    else
      next = terminal ? (wrap ? limit : q) : q - WIDTH'(1);
    halt = div_tick && terminal && !wrap;
    t    = div_tick ? WIDTH'(t_vector(T_MAX_W'(q), T_MAX_W'(next))) : '0;
  end

  // The divider is held clear whenever the controller is idle.
  a_idle_div : assert property (@(posedge clock) disable iff (!resetn)
    (state == IDLE) |-> (div == '0));

endmodule

// File: tb/tb_tff_count_controller.sv
// Self-checking bench for tff_count_controller (WIDTH=4, DIV_MAX=3).
// Inputs are driven just after the falling edge; outputs are sampled
// 1 time unit later, so each row's expectations describe the state left
// by the previous rising edge combined with the row's inputs.
module tb_tff_count_controller;

  logic       clock, resetn, start, stop, dir, wrap;
  logic [3:0] limit, q;
  logic       tick, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  tff_count_controller #(
    .WIDTH   (4),
    .DIV_MAX (3),
    .DIV_W   (2)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .stop   (stop),
    .dir    (dir),
    .wrap   (wrap),
    .limit  (limit),
    .q      (q),
    .tick   (tick),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Each row holds its inputs for n cycles; q/busy/done are expected on
  // every cycle, tick is expected 0 except tick_last on the final cycle.
  typedef struct {
    logic       rn, st, sp, d, w;
    logic [3:0] l;
    int         n;
    logic [3:0] eq;
    logic       eb, ed, et;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rn, st, sp, d, w, input logic [3:0] l,
                     input int n, input logic [3:0] eq,
                     input logic eb, ed, et);
    vec_t v;
    v.rn = rn; v.st = st; v.sp = sp; v.d = d; v.w = w; v.l = l;
    v.n = n; v.eq = eq; v.eb = eb; v.ed = ed; v.et = et;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rn, st, sp, d, w, input logic [3:0] l);
    resetn = rn; start = st; stop = sp; dir = d; wrap = w; limit = l;
  endtask

  task automatic wait_q(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock); #1;
      if (q == target) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic find_tick(output bit found);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      if (tick) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    drive(0, 1, 0, 1, 1, 4'd5);

    //   rn st sp d  w  lim  n  q   b  dn tk
    // Reset held with start=1, then start pulse; up-wrap to limit 5.
    add(0, 1, 0, 1, 1, 4'd5, 2, 4'd0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 4'd5, 1, 4'd0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 4'd5, 4, 4'd0, 1, 0, 1);
    add(1, 0, 0, 1, 1, 4'd5, 4, 4'd1, 1, 0, 1);
    add(1, 0, 0, 1, 1, 4'd5, 4, 4'd2, 1, 0, 1);
    add(1, 0, 0, 1, 1, 4'd5, 4, 4'd3, 1, 0, 1);
    add(1, 0, 0, 1, 1, 4'd5, 4, 4'd4, 1, 0, 1);
    add(1, 0, 0, 1, 1, 4'd5, 4, 4'd5, 1, 0, 1);
    add(1, 0, 0, 1, 1, 4'd5, 4, 4'd0, 1, 0, 1);
    add(1, 0, 0, 1, 1, 4'd5, 1, 4'd1, 1, 0, 0);
    add(1, 0, 0, 1, 1, 4'd5, 3, 4'd1, 1, 0, 1);
    add(1, 0, 0, 1, 1, 4'd5, 4, 4'd2, 1, 0, 1);
    // Down with halt from 3: 2,1,0, then terminal halt and done pulse.
    add(1, 0, 0, 0, 0, 4'd5, 4, 4'd3, 1, 0, 1);
    add(1, 0, 0, 0, 0, 4'd5, 4, 4'd2, 1, 0, 1);
    add(1, 0, 0, 0, 0, 4'd5, 4, 4'd1, 1, 0, 1);
    add(1, 0, 0, 0, 0, 4'd5, 4, 4'd0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 4'd5, 1, 4'd0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'd5, 2, 4'd0, 0, 0, 0);
    // Down wrap from 0 to limit 9, then 8; dir flipped up -> 9 -> 0.
    add(1, 1, 0, 0, 1, 4'd9, 1, 4'd0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 4'd9, 4, 4'd0, 1, 0, 1);
    add(1, 0, 0, 0, 1, 4'd9, 4, 4'd9, 1, 0, 1);
    add(1, 0, 0, 1, 1, 4'd9, 4, 4'd8, 1, 0, 1);
    add(1, 0, 0, 1, 1, 4'd9, 4, 4'd9, 1, 0, 1);
    add(1, 0, 0, 1, 1, 4'd9, 1, 4'd0, 1, 0, 0);
    // Stop on the div==3 cycle suppresses the tick; start+stop stays idle.
    add(1, 0, 0, 1, 1, 4'd9, 2, 4'd0, 1, 0, 0);
    add(1, 0, 1, 1, 1, 4'd9, 1, 4'd0, 1, 0, 0);
    add(1, 0, 0, 1, 1, 4'd9, 1, 4'd0, 0, 0, 0);
    add(1, 1, 1, 1, 1, 4'd9, 2, 4'd0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 4'd9, 1, 4'd0, 0, 0, 0);

    foreach (vecs[k]) begin
      for (int c = 0; c < vecs[k].n; c++) begin
        @(negedge clock);
        drive(vecs[k].rn, vecs[k].st, vecs[k].sp, vecs[k].d, vecs[k].w, vecs[k].l);
        #1;
        check($sformatf("row%0d.q", k),    32'(q),    32'(vecs[k].eq));
        check($sformatf("row%0d.busy", k), 32'(busy), 32'(vecs[k].eb));
        check($sformatf("row%0d.done", k), 32'(done), 32'(vecs[k].ed));
        check($sformatf("row%0d.tick", k), 32'(tick),
              32'((c == vecs[k].n - 1) ? vecs[k].et : 1'b0));
      end
    end

    // Reset in the middle of a run at q=7.
    @(negedge clock); drive(1, 1, 0, 1, 1, 4'd15);
    @(negedge clock); drive(1, 0, 0, 1, 1, 4'd15);
    wait_q(4'd7, ok);
    check("reach_q7_a", 32'(ok), 32'd1);
    resetn = 1'b0;
    @(negedge clock); #1;
    check("midrst.q", 32'(q), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.tick", 32'(tick), 32'd0);
    drive(1, 1, 0, 1, 1, 4'd15);
    @(negedge clock); drive(1, 0, 0, 1, 1, 4'd15);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      check($sformatf("rst_first_tick%0d", c), 32'(tick), 32'(c == 3));
    end

    // Limit lowered below q with wrap=1: next tick wraps to 0.
    wait_q(4'd7, ok);
    check("reach_q7_b", 32'(ok), 32'd1);
    limit = 4'd4;
    find_tick(ok);
    check("lowlim_wrap.tick_seen", 32'(ok), 32'd1);
    check("lowlim_wrap.q_pre", 32'(q), 32'd7);
    @(negedge clock); #1;
    check("lowlim_wrap.q", 32'(q), 32'd0);
    check("lowlim_wrap.busy", 32'(busy), 32'd1);

    // Same with wrap=0: halt at 7 with a one-cycle done.
    limit = 4'd15;
    wait_q(4'd7, ok);
    check("reach_q7_c", 32'(ok), 32'd1);
    limit = 4'd4;
    wrap  = 1'b0;
    find_tick(ok);
    check("lowlim_halt.tick_seen", 32'(ok), 32'd1);
    @(negedge clock); #1;
    check("lowlim_halt.q", 32'(q), 32'd7);
    check("lowlim_halt.busy", 32'(busy), 32'd0);
    check("lowlim_halt.done", 32'(done), 32'd1);
    @(negedge clock); #1;
    check("lowlim_halt.done_clr", 32'(done), 32'd0);
    check("lowlim_halt.q_hold", 32'(q), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
